// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, pipeline register controls out.
// Optional performance counters appear only when HAZARD_PERF_CNT_EN is defined.
// Handshake: there is no valid/ready pair here. Every control is a level signal
// that applies to the cycle in which the causing status inputs are presented.
// mem_req/mem_ready behave as a request/acknowledge pair: an access completes
// on the first cycle in which both mem_req and mem_ready are high.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        mem_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_mem_flush;
  logic        pipe_freeze;
  logic        mem_timeout;
  logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic [15:0] wait_count;

  // Pipeline side: supplies status, consumes controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
           pipe_freeze, mem_timeout, state, stall_count, flush_count, wait_count
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
           pipe_freeze, mem_timeout, state, stall_count, flush_count, wait_count
  );
`else
  // Pipeline side: supplies status, consumes controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
           pipe_freeze, mem_timeout, state
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rd,
           mem_branch_taken, mem_req, mem_ready,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_flush,
           pipe_freeze, mem_timeout, state
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline.
// Handles load-use stalls, taken-branch flushes and data-memory wait freezes,
// with a sticky timeout on memory waits. All controls are combinational from
// the current state and inputs, so they act in the cycle of the cause.
// Optional feature macro: HAZARD_PERF_CNT_EN adds saturating stall/flush/wait
// cycle counters.
module pipeline_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,   // bubbles per load-use hazard (1..15)
  parameter int MEM_TIMEOUT     = 255  // max consecutive wait cycles (1..255)
) (
  input logic                  clk,
  input logic                  reset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       timeout_q, timeout_d;

  logic       wait_ev, branch_ev, lu_ev;
  logic       eval, allow_wait, allow_branch, allow_lu;

  logic       pc_write_c, if_id_write_c, if_id_flush_c;
  logic       id_ex_bubble_c, ex_mem_flush_c, pipe_freeze_c;

  // Raw event detection; r0 is hardwired to zero so ex_rd==0 never stalls.
  always_comb begin
    wait_ev   = hz.mem_req & ~hz.mem_ready & ~timeout_q;
    branch_ev = hz.mem_branch_taken;
    lu_ev     = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                ((hz.ex_rd == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rd == hz.id_rt)));
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      stall_cnt_q <= 4'd0;
      wait_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and control outputs. Each state either produces its own
  // outputs or hands over to the shared priority evaluation (wait > branch >
  // load-use) with a per-state mask of which events may fire.
  always_comb begin
    pc_write_c     = 1'b1;
    if_id_write_c  = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    ex_mem_flush_c = 1'b0;
    pipe_freeze_c  = 1'b0;
    state_d        = state_q;
    stall_cnt_d    = stall_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    timeout_d      = timeout_q;
    eval           = 1'b0;
    allow_wait     = 1'b0;
    allow_branch   = 1'b0;
    allow_lu       = 1'b0;

    case (state_q)
      RUN: begin
        eval         = 1'b1;
        allow_wait   = 1'b1;
        allow_branch = 1'b1;
        allow_lu     = 1'b1;
      end
      FLUSH: begin
        // Flushed slots hold NOPs, so only a memory wait is meaningful here.
        eval       = 1'b1;
        allow_wait = 1'b1;
      end
      LU_STALL: begin
        if (wait_ev || branch_ev) begin
          eval         = 1'b1;
          allow_wait   = 1'b1;
          allow_branch = 1'b1;
          stall_cnt_d  = 4'd0;
        end else begin
          pc_write_c     = 1'b0;
          if_id_write_c  = 1'b0;
          id_ex_bubble_c = 1'b1;
          if (stall_cnt_q <= 4'd1) begin
            stall_cnt_d = 4'd0;
            state_d     = RUN;
          end else begin
            stall_cnt_d = stall_cnt_q - 4'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (wait_ev && (wait_cnt_q != 8'(MEM_TIMEOUT))) begin
          pc_write_c    = 1'b0;
          if_id_write_c = 1'b0;
          pipe_freeze_c = 1'b1;
          wait_cnt_d    = wait_cnt_q + 8'd1;
        end else begin
          // Ready or timeout cycle: freeze drops now and the remaining
          // events are evaluated as in RUN. On timeout the wait itself is
          // masked since the sticky flag only takes effect next cycle.
          eval         = 1'b1;
          allow_branch = 1'b1;
          allow_lu     = 1'b1;
          wait_cnt_d   = 8'd0;
          if (wait_ev) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (eval) begin
      if (allow_wait && wait_ev) begin
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        pipe_freeze_c = 1'b1;
        wait_cnt_d    = 8'd1;
        stall_cnt_d   = 4'd0;
        state_d       = MEM_WAIT;
      end else if (allow_branch && branch_ev) begin
        pc_write_c     = 1'b1;
        if_id_flush_c  = 1'b1;
        id_ex_bubble_c = 1'b1;
        ex_mem_flush_c = 1'b1;
        stall_cnt_d    = 4'd0;
        state_d        = FLUSH;
      end else if (allow_lu && lu_ev) begin
        pc_write_c     = 1'b0;
        if_id_write_c  = 1'b0;
        id_ex_bubble_c = 1'b1;
        if (LU_STALL_CYCLES > 1) begin
          stall_cnt_d = 4'(LU_STALL_CYCLES - 1);
          state_d     = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end

    // While reset is held the pipeline is emptied and nothing advances.
    if (!reset_n) begin
      pc_write_c     = 1'b0;
      if_id_write_c  = 1'b0;
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
      ex_mem_flush_c = 1'b1;
      pipe_freeze_c  = 1'b0;
    end
  end

  assign hz.pc_write     = pc_write_c;
  assign hz.if_id_write  = if_id_write_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_bubble = id_ex_bubble_c;
  assign hz.ex_mem_flush = ex_mem_flush_c;
  assign hz.pipe_freeze  = pipe_freeze_c;
  assign hz.mem_timeout  = timeout_q;
  assign hz.state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count_q, flush_count_q, wait_count_q;

  // Saturating cycle counters for bubbles, flushes and freezes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count_q <= 16'd0;
      flush_count_q <= 16'd0;
      wait_count_q  <= 16'd0;
    end else begin
      if (id_ex_bubble_c && !if_id_flush_c && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
      if (if_id_flush_c && (flush_count_q != 16'hFFFF))
        flush_count_q <= flush_count_q + 16'd1;
      if (pipe_freeze_c && (wait_count_q != 16'hFFFF))
        wait_count_q <= wait_count_q + 16'd1;
    end
  end

  assign hz.stall_count = stall_count_q;
  assign hz.flush_count = flush_count_q;
  assign hz.wait_count  = wait_count_q;
`endif

endmodule
